// File: rtl/hann_ram_pkg.sv
// Shared constants for the Hann-window coefficient RAM: default geometry
// and the write-mode names accepted by the WRITE_MODE parameter.
package hann_ram_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 9;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    localparam string WM_NORMAL      = "NORMAL_WRITE";
    localparam string WM_TRANSPARENT = "TRANSPARENT_WRITE";
    localparam string WM_READ_FIRST  = "READ_BEFORE_WRITE";

endpackage

// File: rtl/hann_ram_array.sv
// Bare single-port storage: one write port and one registered read port
// sharing an address. The read register's write-cycle behaviour is set by WRITE_MODE.
module hann_ram_array
    import hann_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter string       WRITE_MODE = WM_NORMAL
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam bit          MODE_TRANS = (WRITE_MODE == WM_TRANSPARENT);
    localparam bit          MODE_RBW   = (WRITE_MODE == WM_READ_FIRST);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  wr_ok_c;

    // Writes are dropped while reset is held; the array itself is never cleared.
    assign wr_ok_c = wr_en & ~tb_rst;

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[addr] <= wr_data;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (!wr_en) begin
            rd_d = mem_q[addr];
        end else if (MODE_TRANS) begin
            rd_d = wr_data;
        end else if (MODE_RBW) begin
            rd_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/hann_ram_sp.sv
// Hann-window coefficient RAM for the voice FFT path: wraps the storage array
// and adds the optional second output register (latency 2 when OUTPUT_REG=1).
module hann_ram_sp
    import hann_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter string       WRITE_MODE = WM_NORMAL,
    parameter int unsigned OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] arr_rd;

    hann_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WRITE_MODE (WRITE_MODE)
    ) u_array (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_data (arr_rd)
    );

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        logic [DATA_WIDTH-1:0] out_d;

        always_comb begin
            out_d = arr_rd;
        end

        always_ff @(posedge clk or posedge tb_rst) begin
            if (tb_rst) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign rd_data = out_q;
    end else begin : g_no_out_reg
        assign rd_data = arr_rd;
    end

endmodule

// File: tb/tb_hann_ram_sp.sv
// Self-checking bench for hann_ram_sp (defaults: 512x16, NORMAL_WRITE, no output register).
module tb_hann_ram_sp;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk;
    logic          tb_rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [DW-1:0] rd_data;

    int n_checks;
    int n_fail;

    // Behavioural reference: plain array plus expected read-port value.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_rd;

    hann_ram_sp dut (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clocked operation; inputs change 1 ns after the edge, output checked 1 ns after the next.
    task automatic do_op(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = we;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        if (tb_rst) begin
            exp_rd = '0;
        end else if (we) begin
            model_mem[a] = d;
        end else begin
            exp_rd = model_mem[a];
        end
        #1;
        check(tag, rd_data, exp_rd);
    endtask

    logic [DW-1:0] saved;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_rd   = '0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        addr    = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("por_reset", rd_data, 16'h0000);
        tb_rst = 1'b0;

        // Reset with a nonzero read value: clears at once, stays cleared across a write.
        do_op("pre_wr", 1'b1, 9'd3, 16'hBEEF);
        do_op("pre_rd", 1'b0, 9'd3, 16'h0000);
        check("pre_nonzero", rd_data, 16'hBEEF);
        #3;
        tb_rst = 1'b1;
        #1;
        check("rst_async", rd_data, 16'h0000);
        #199;
        check("rst_hold", rd_data, 16'h0000);
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        exp_rd = '0;
        do_op("rst_wr_hold", 1'b1, 9'd4, 16'h7777);
        check("rst_stays0", rd_data, 16'h0000);

        // Full write sweep 1..511 then 0, data FFFF downward.
        for (int i = 1; i <= int'(DEPTH); i++) begin
            do_op("wsweep_hold", 1'b1, AW'(i), DW'(32'hFFFF - 32'(i - 1)));
        end

        // Full read sweep in the same order.
        for (int i = 1; i <= int'(DEPTH); i++) begin
            do_op("rsweep_model", 1'b0, AW'(i), 16'h0000);
            check("rsweep_val", rd_data, DW'(32'hFFFF - 32'(i - 1)));
        end
        do_op("rd_1", 1'b0, 9'd1, 16'h0);
        check("mem1", rd_data, 16'hFFFF);
        do_op("rd_2", 1'b0, 9'd2, 16'h0);
        check("mem2", rd_data, 16'hFFFE);
        do_op("rd_511", 1'b0, 9'd511, 16'h0);
        check("mem511", rd_data, 16'hFE01);
        do_op("rd_0", 1'b0, 9'd0, 16'h0);
        check("mem0", rd_data, 16'hFE00);

        // NORMAL_WRITE: read port holds during a write.
        do_op("nw_rd", 1'b0, 9'd5, 16'h0);
        check("nw_old", rd_data, 16'hFFFB);
        do_op("nw_wr", 1'b1, 9'd5, 16'h1234);
        check("nw_hold", rd_data, 16'hFFFB);
        do_op("nw_rd2", 1'b0, 9'd5, 16'h0);
        check("nw_new", rd_data, 16'h1234);

        // Back-to-back write then read of the same address.
        do_op("b2b_wr", 1'b1, 9'd10, 16'hA5A5);
        do_op("b2b_rd", 1'b0, 9'd10, 16'h0);
        check("b2b_val", rd_data, 16'hA5A5);

        // Reset pulse mid-read-sweep; writes during reset are dropped.
        for (int i = 20; i < 24; i++) do_op("mid_rd", 1'b0, AW'(i), 16'h0);
        saved = model_mem[20];
        #2;
        tb_rst = 1'b1;
        #1;
        check("mid_rst_async", rd_data, 16'h0000);
        do_op("mid_rst_wr20", 1'b1, 9'd20, 16'hDEAD);
        do_op("mid_rst_wr21", 1'b1, 9'd21, 16'hBEEF);
        tb_rst = 1'b0;
        do_op("mid_rerd20", 1'b0, 9'd20, 16'h0);
        check("mid_keep20", rd_data, saved);
        do_op("mid_rerd21", 1'b0, 9'd21, 16'h0);
        check("mid_keep21", rd_data, 16'hFFEB);

        // Randomized mix of reads and writes against the model.
        for (int i = 0; i < 400; i++) begin
            do_op("rand", 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
